// File: rtl/onc_reg_file_if.sv
// Register-file access bus for the ONC-16 datapath: two read address/data
// pairs driven by decode, one write port driven by writeback.
interface onc_reg_file_if #(
  parameter int DATA_W    = 16,
  parameter int RF_ADDR_W = 4
);
  logic [RF_ADDR_W-1:0] r1_addr;
  logic [RF_ADDR_W-1:0] r2_addr;
  logic [RF_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]    w_data;
  logic                 we;
  logic [DATA_W-1:0]    r1_data;
  logic [DATA_W-1:0]    r2_data;

  // Decode/writeback side: drives addresses and write data, receives read data.
  modport master (
    output r1_addr, r2_addr, w_addr, w_data, we,
    input  r1_data, r2_data
  );

  // Register-file side.
  modport slave (
    input  r1_addr, r2_addr, w_addr, w_data, we,
    output r1_data, r2_data
  );
endinterface

// File: rtl/onc_reg_file.sv
// ONC-16 general-purpose register file: 2**RF_ADDR_W words of DATA_W bits,
// two combinational read ports and one rising-edge write port. An
// asynchronous reset (n_rst, active-high despite its name) clears every word
// and overrides any write on the same edge. Register 0 is an ordinary register.
module onc_reg_file #(
  parameter int DATA_W    = 16,
  parameter int RF_ADDR_W = 4
) (
  input  logic           clock,
  input  logic           n_rst,
  onc_reg_file_if.slave  bus
);

  localparam int DEPTH = 2 ** RF_ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next-state array: only the addressed word takes the write data when enabled.
  always_comb begin
    mem_d = mem_q;
    if (bus.we) begin
      mem_d[bus.w_addr] = bus.w_data;
    end
  end

  // Storage: asynchronous clear has priority over the clocked write.
  always_ff @(posedge clock or posedge n_rst) begin
    if (n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports are pure combinational lookups with no write forwarding, so a
  // same-address write becomes visible only after its clock edge.
  assign bus.r1_data = mem_q[bus.r1_addr];
  assign bus.r2_data = mem_q[bus.r2_addr];

endmodule

// File: tb/tb_onc_reg_file.sv
// Directed bench for onc_reg_file: a behavioural array model produces the
// expected read data, which is queued when the read addresses are driven and
// popped for comparison once the combinational outputs have settled.
module tb_onc_reg_file;

  localparam int DATA_W    = 16;
  localparam int RF_ADDR_W = 4;
  localparam int DEPTH     = 2 ** RF_ADDR_W;

  logic clock;
  logic n_rst;

  onc_reg_file_if #(.DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W)) bus ();

  onc_reg_file #(.DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W)) dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DATA_W-1:0]   model [DEPTH];
  logic [2*DATA_W-1:0] sb_q [$];
  int vectors;
  int miscompares;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One clock edge; the model follows the same reset-over-write priority.
  task automatic tick();
    @(posedge clock);
    if (n_rst) model_clear();
    else if (bus.we) model[bus.w_addr] = bus.w_data;
    @(negedge clock);
  endtask

  // Queue the model's answer for the current read addresses, let the
  // combinational path settle, then pop and compare both ports.
  task automatic check(input string tag);
    logic [2*DATA_W-1:0] exp_v;
    sb_q.push_back({model[bus.r1_addr], model[bus.r2_addr]});
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    assert (bus.r1_data === exp_v[2*DATA_W-1:DATA_W]) else begin
      miscompares++;
      $error("FAIL %s r1 addr=%0d observed=%h expected=%h", tag, bus.r1_addr,
             bus.r1_data, exp_v[2*DATA_W-1:DATA_W]);
    end
    vectors++;
    assert (bus.r2_data === exp_v[DATA_W-1:0]) else begin
      miscompares++;
      $error("FAIL %s r2 addr=%0d observed=%h expected=%h", tag, bus.r2_addr,
             bus.r2_data, exp_v[DATA_W-1:0]);
    end
  endtask

  task automatic write_reg(input int a, input logic [DATA_W-1:0] d);
    bus.we     = 1'b1;
    bus.w_addr = RF_ADDR_W'(a);
    bus.w_data = d;
    tick();
    bus.we     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_clear();
    n_rst       = 1'b0;
    bus.we      = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.r1_addr = '0;
    bus.r2_addr = '0;
    @(negedge clock);

    // Reset state: asserted between edges, outputs read zero at once.
    n_rst = 1'b1;
    model_clear();
    bus.r1_addr = 4'd0;
    bus.r2_addr = 4'd15;
    check("reset_state");
    tick();
    n_rst = 1'b0;

    // 1. we=0 sweep with all-ones write data: nothing may change.
    bus.we     = 1'b0;
    bus.w_data = 16'hFFFF;
    for (int w = 0; w < DEPTH; w++) begin
      bus.w_addr = RF_ADDR_W'(w);
      for (int a = 0; a < DEPTH; a++) begin
        for (int b = 0; b < DEPTH; b++) begin
          bus.r1_addr = RF_ADDR_W'(a);
          bus.r2_addr = RF_ADDR_W'(b);
          check("we0_sweep");
        end
      end
      tick();
    end

    // 2. Full write sweep; the next address is still zero before its edge.
    bus.w_data = 16'hFFFF;
    for (int a = 0; a < DEPTH; a++) begin
      bus.we      = 1'b1;
      bus.w_addr  = RF_ADDR_W'(a);
      bus.r1_addr = RF_ADDR_W'(a);
      bus.r2_addr = RF_ADDR_W'((a + 1) % DEPTH);
      check("wr_sweep_pre");
      tick();
      bus.r2_addr = RF_ADDR_W'(a);
      check("wr_sweep_post");
    end
    bus.we = 1'b0;

    // 3. Read-during-write on reg8: no forwarding.
    write_reg(8, 16'h0000);
    bus.r1_addr = 4'd8;
    bus.r2_addr = 4'd7;
    bus.we      = 1'b1;
    bus.w_addr  = 4'd8;
    bus.w_data  = 16'h8000;
    check("rdw_before_edge");
    tick();
    check("rdw_after_edge1");
    #1;
    bus.w_data = 16'h0008;
    check("rdw_mid_cycle");
    tick();
    check("rdw_after_edge2");
    bus.we = 1'b0;

    // 4. Dual-port independence and same-cycle swap.
    write_reg(3, 16'h1234);
    write_reg(12, 16'hABCD);
    bus.r1_addr = 4'd3;
    bus.r2_addr = 4'd12;
    check("dual_port");
    bus.r1_addr = 4'd12;
    bus.r2_addr = 4'd3;
    check("dual_swap");
    bus.r2_addr = 4'd12;
    check("same_addr");

    // 5. Reset mid-operation after filling with 16'h5A5A.
    for (int a = 0; a < DEPTH; a++) write_reg(a, 16'h5A5A);
    bus.r1_addr = 4'd0;
    bus.r2_addr = 4'd9;
    check("fill_5a5a");
    #1;
    n_rst = 1'b1;
    model_clear();
    check("async_reset");
    bus.we     = 1'b1;
    bus.w_addr = 4'd5;
    bus.w_data = 16'h1111;
    bus.r1_addr = 4'd5;
    tick();
    check("write_in_reset");
    bus.we = 1'b0;
    n_rst  = 1'b0;
    tick();
    check("after_reset_release");

    // 6. Write isolation: distinct contents, then reg15 written.
    for (int a = 0; a < DEPTH; a++) write_reg(a, DATA_W'(16'h0101 * (a + 1)));
    write_reg(15, 16'h7FFF);
    bus.r1_addr = 4'd15;
    bus.r2_addr = 4'd15;
    check("iso_reg15");
    for (int a = 0; a < DEPTH - 1; a++) begin
      bus.r1_addr = RF_ADDR_W'(a);
      bus.r2_addr = RF_ADDR_W'(DEPTH - 2 - a);
      check("isolation");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
